// File: rtl/text_entry_pkg.sv
// Shared types and constants for the keyboard-to-character-buffer text entry path.
package text_entry_pkg;

  localparam int unsigned CODE_W = 9;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  localparam logic [CODE_W-1:0] SC_LSHIFT = 9'h012;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 9'h059;
  localparam logic [CODE_W-1:0] SC_CAPS   = 9'h058;
  localparam logic [CODE_W-1:0] SC_ENTER  = 9'h05A;
  localparam logic [CODE_W-1:0] SC_BKSP   = 9'h066;
  localparam logic [CODE_W-1:0] SC_ESC    = 9'h076;
  localparam logic [CODE_W-1:0] SC_SPACE  = 9'h029;

  localparam logic [DATA_W-1:0] ASCII_SPACE = 8'h20;

  // Captured key press: modifier state is frozen at capture time.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              shift;
    logic              caps;
  } key_evt_t;

  // Caps Lock only affects letter keys.
  function automatic logic is_letter(input logic [CODE_W-1:0] code);
    case (code)
      9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033,
      9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D,
      9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022,
      9'h035, 9'h01A: is_letter = 1'b1;
      default:        is_letter = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/text_entry_ctrl_scan_to_ascii.sv
// Set-2 scan code to ASCII for letters, digits and punctuation; upper selects the shifted glyph.
module scan_to_ascii
  import text_entry_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              upper,
  output logic [DATA_W-1:0] ascii,
  output logic              printable
);

  always_comb begin
    ascii     = '0;
    printable = 1'b1;
    case (code)
      9'h01C: ascii = upper ? "A" : "a";
      9'h032: ascii = upper ? "B" : "b";
      9'h021: ascii = upper ? "C" : "c";
      9'h023: ascii = upper ? "D" : "d";
      9'h024: ascii = upper ? "E" : "e";
      9'h02B: ascii = upper ? "F" : "f";
      9'h034: ascii = upper ? "G" : "g";
      9'h033: ascii = upper ? "H" : "h";
      9'h043: ascii = upper ? "I" : "i";
      9'h03B: ascii = upper ? "J" : "j";
      9'h042: ascii = upper ? "K" : "k";
      9'h04B: ascii = upper ? "L" : "l";
      9'h03A: ascii = upper ? "M" : "m";
      9'h031: ascii = upper ? "N" : "n";
      9'h044: ascii = upper ? "O" : "o";
      9'h04D: ascii = upper ? "P" : "p";
      9'h015: ascii = upper ? "Q" : "q";
      9'h02D: ascii = upper ? "R" : "r";
      9'h01B: ascii = upper ? "S" : "s";
      9'h02C: ascii = upper ? "T" : "t";
      9'h03C: ascii = upper ? "U" : "u";
      9'h02A: ascii = upper ? "V" : "v";
      9'h01D: ascii = upper ? "W" : "w";
      9'h022: ascii = upper ? "X" : "x";
      9'h035: ascii = upper ? "Y" : "y";
      9'h01A: ascii = upper ? "Z" : "z";
      9'h045: ascii = upper ? 8'h29 : 8'h30;
      9'h016: ascii = upper ? 8'h21 : 8'h31;
      9'h01E: ascii = upper ? 8'h40 : 8'h32;
      9'h026: ascii = upper ? 8'h23 : 8'h33;
      9'h025: ascii = upper ? 8'h24 : 8'h34;
      9'h02E: ascii = upper ? 8'h25 : 8'h35;
      9'h036: ascii = upper ? 8'h5E : 8'h36;
      9'h03D: ascii = upper ? 8'h26 : 8'h37;
      9'h03E: ascii = upper ? 8'h2A : 8'h38;
      9'h046: ascii = upper ? 8'h28 : 8'h39;
      9'h00E: ascii = upper ? 8'h7E : 8'h60;
      9'h04E: ascii = upper ? 8'h5F : 8'h2D;
      9'h055: ascii = upper ? 8'h2B : 8'h3D;
      9'h054: ascii = upper ? 8'h7B : 8'h5B;
      9'h05B: ascii = upper ? 8'h7D : 8'h5D;
      9'h05D: ascii = upper ? 8'h7C : 8'h5C;
      9'h04C: ascii = upper ? 8'h3A : 8'h3B;
      9'h052: ascii = upper ? 8'h22 : 8'h27;
      9'h041: ascii = upper ? 8'h3C : 8'h2C;
      9'h049: ascii = upper ? 8'h3E : 8'h2E;
      9'h04A: ascii = upper ? 8'h3F : 8'h2F;
      default: printable = 1'b0;
    endcase
  end

endmodule

// File: rtl/text_entry_ctrl.sv
// Text entry controller: key capture, edit FSM, cursor/clear counters and the shared
// single-port memory mux where the display scanner always wins.
module text_entry_ctrl
  import text_entry_pkg::*;
#(
  parameter  int unsigned COLS = 16,
  parameter  int unsigned ROWS = 4,
  localparam int unsigned N    = COLS * ROWS,
  localparam int unsigned AW   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [CODE_W-1:0]   last_change,
  input  logic [511:0]        key_down,
  input  logic                disp_req,
  input  logic [AW-1:0]       disp_addr,
  output logic                disp_gnt,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [AW-1:0]       cursor,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  state_e            state_q, state_d;
  key_evt_t          pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  key_evt_t          cur_q, cur_d;
  logic              caps_q, caps_d;
  logic [AW-1:0]     cursor_q, cursor_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              adv_q, adv_d;
  logic [7:0]        drop_q, drop_d;

  logic              press_c;
  logic              shift_c;
  logic              upper_c;
  logic              consume_c;
  logic [DATA_W-1:0] ascii_c;
  logic              printable_c;

  assign press_c = key_valid && key_down[last_change];
  assign shift_c = key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
  assign upper_c = cur_q.shift ^ (cur_q.caps & is_letter(cur_q.code));

  scan_to_ascii u_scan_to_ascii (
    .code      (cur_q.code),
    .upper     (upper_c),
    .ascii     (ascii_c),
    .printable (printable_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cur_q      <= '0;
      caps_q     <= 1'b0;
      cursor_q   <= '0;
      clr_q      <= '0;
      wdata_q    <= '0;
      adv_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cur_q      <= cur_d;
      caps_q     <= caps_d;
      cursor_q   <= cursor_d;
      clr_q      <= clr_d;
      wdata_q    <= wdata_d;
      adv_q      <= adv_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cur_d      = cur_q;
    caps_d     = caps_q;
    cursor_d   = cursor_q;
    clr_d      = clr_q;
    wdata_d    = wdata_q;
    adv_d      = adv_q;
    drop_d     = drop_q;
    consume_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          cur_d     = pend_q;
          consume_c = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (cur_q.code == SC_SPACE) begin
          wdata_d = ASCII_SPACE;
          adv_d   = 1'b1;
          state_d = ST_WRITE;
        end else if (printable_c) begin
          wdata_d = ascii_c;
          adv_d   = 1'b1;
          state_d = ST_WRITE;
        end else if (cur_q.code == SC_BKSP) begin
          if (cursor_q != '0) begin
            cursor_d = cursor_q - AW'(1);
            wdata_d  = ASCII_SPACE;
            adv_d    = 1'b0;
            state_d  = ST_WRITE;
          end
        end else if (cur_q.code == SC_ENTER) begin
          if (32'(cursor_q) >= N - COLS) cursor_d = '0;
          else cursor_d = AW'((32'(cursor_q) / COLS + 32'd1) * COLS);
        end else if (cur_q.code == SC_ESC) begin
          clr_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_WRITE: begin
        if (!disp_req) begin
          if (adv_q) cursor_d = (cursor_q == LAST_ADDR) ? '0 : cursor_q + AW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!disp_req) begin
          clr_d = clr_q + AW'(1);
          if (clr_q == LAST_ADDR) begin
            clr_d    = '0;
            cursor_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Caps toggles on capture regardless of FSM or pending occupancy.
    if (press_c && last_change == SC_CAPS) caps_d = ~caps_q;

    if (consume_c) pend_vld_d = 1'b0;
    if (press_c) begin
      if (!pend_vld_q || consume_c) begin
        pend_vld_d   = 1'b1;
        pend_d.code  = last_change;
        pend_d.shift = shift_c;
        pend_d.caps  = caps_q;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Port mux: combinational from registered state plus the display request.
  always_comb begin
    disp_gnt  = disp_req;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (state_q == ST_WRITE) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cursor_q;
      mem_wdata = wdata_q;
    end else if (state_q == ST_CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_q;
      mem_wdata = ASCII_SPACE;
    end
  end

  assign cursor   = cursor_q;
  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = drop_q;

endmodule
